// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
// State encoding, grant identifiers and default widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Purpose: 2-way round-robin picker between fetch and data requests.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req_fetch,
  input  logic req_data,
  input  logic rr_last,
  output logic vld,
  output logic win
);

  always_comb begin
    vld = req_fetch | req_data;
    win = GNT_FETCH;
    // On a tie the port that did not win last time goes first.
    if (req_fetch && req_data) begin
      win = (rr_last == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    end else if (req_data) begin
      win = GNT_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin share of one single-port memory between instruction fetch and load/store; ARB_TIMEOUT_EN adds an err watchdog.
// Latency: req -> mem_req next cycle; mem_ack -> port ack next cycle; next grant's mem_req two cycles after the ack.
// Backpressure: requesters hold req until their ack; the memory stalls by withholding mem_ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
`ifdef ARB_TIMEOUT_EN
  output logic              err,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_t state;
  logic       gnt;
  logic       rr_last;
  logic       pick_vld;
  logic       pick_win;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt;
`endif

  rr_pick2 u_pick (
    .req_fetch (if_req),
    .req_data  (d_req),
    .rr_last   (rr_last),
    .vld       (pick_vld),
    .win       (pick_win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      gnt       <= GNT_FETCH;
      rr_last   <= GNT_FETCH;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err       <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt     <= pick_win;
            rr_last <= pick_win;
            mem_req <= 1'b1;
            state   <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
            if (pick_win == GNT_DATA) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        ST_BUSY: begin
`ifdef ARB_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`endif
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_RESP;
            if (gnt == GNT_FETCH) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              // Stores leave the load data register untouched.
              if (!mem_we) d_rdata <= mem_rdata;
              d_ack <= 1'b1;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            mem_req <= 1'b0;
            state   <= ST_RESP;
            err     <= 1'b1;
            if (gnt == GNT_FETCH) if_ack <= 1'b1;
            else                  d_ack  <= 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          err    <= 1'b0;
`endif
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scoreboard of expected memory transactions.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_ack, d_ack, mem_req, mem_we;
`ifdef ARB_TIMEOUT_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
`ifdef ARB_TIMEOUT_EN
    .err       (err),
`endif
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  typedef struct {
    logic          port;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            errs    = 0;
  logic [DW-1:0] exp_if_rdata = '0;
  logic [DW-1:0] exp_d_rdata  = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic [AW-1:0] addr, input logic we,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    exp_t e;
    e.port = port; e.addr = addr; e.we = we; e.wdata = wdata; e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Memory side: wait for the next request, check it against the scoreboard,
  // ack after lat BUSY cycles and check the port response in the RESP cycle.
  task automatic serve(input int lat, input bit scramble, output int waited);
    exp_t e;
    bit   found;
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
      waited++;
    end
    e = sb.pop_front();
    if (!found) begin
      chk("mem_req_wait", {31'd0, mem_req}, 32'd1);
      return;
    end
    chk("mem_addr", mem_addr, e.addr);
    chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
    if (scramble) begin
      if_addr = ~if_addr; d_addr = ~d_addr; d_wdata = ~d_wdata; d_we = ~d_we;
    end
    for (int i = 1; i < lat; i++) begin
      tick();
      chk("mem_req_hold", {31'd0, mem_req}, 32'd1);
      chk("mem_addr_hold", mem_addr, e.addr);
    end
    mem_rdata = e.rdata;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (e.port == GNT_FETCH) exp_if_rdata = e.rdata;
    else if (!e.we)          exp_d_rdata  = e.rdata;
    chk("if_ack", {31'd0, if_ack}, {31'd0, e.port == GNT_FETCH});
    chk("d_ack", {31'd0, d_ack}, {31'd0, e.port == GNT_DATA});
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
`ifdef ARB_TIMEOUT_EN
    chk("err_clear", {31'd0, err}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int w;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) tick();

    // Reset values
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
`ifdef ARB_TIMEOUT_EN
    chk("rst_err", {31'd0, err}, 32'd0);
`endif
    rst = 1'b1;
    tick();

    // Fetch only, memory acks in cycle 3; fields scrambled while BUSY
    if_addr = 32'h0000_0010; if_req = 1'b1;
    push(GNT_FETCH, 32'h10, 1'b0, '0, 32'h0073_8663);
    serve(3, 1'b1, w);
    chk("fetch_grant_latency", w, 32'd1);
    if_req = 1'b0;
    tick();
    chk("idle_no_regrant", {31'd0, mem_req}, 32'd0);
    chk("if_rdata_hold", if_rdata, exp_if_rdata);

    // Stray mem_ack in IDLE is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("stray_ack_req", {31'd0, mem_req}, 32'd0);

    // Simultaneous first requests after reset: data then fetch
    rst = 1'b0; tick(); rst = 1'b1; tick();
    exp_if_rdata = '0; exp_d_rdata = '0;
    d_addr = 32'h100; d_we = 1'b0; if_addr = 32'h200;
    d_req = 1'b1; if_req = 1'b1;
    push(GNT_DATA, 32'h100, 1'b0, '0, 32'hA1A1_0001);
    push(GNT_FETCH, 32'h200, 1'b0, '0, 32'hB2B2_0002);
    serve(2, 1'b0, w);
    d_addr = 32'h104;
    tick();
    chk("gap_cycle", {31'd0, mem_req}, 32'd0);
    tick();
    chk("regrant_cycle", {31'd0, mem_req}, 32'd1);
    serve(1, 1'b0, w);
    if_addr = 32'h204;

    // Continuous contention, 1-cycle memory: D,F,D,F,D,F
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push(GNT_DATA, d_addr, 1'b0, '0, $urandom);
      else            push(GNT_FETCH, if_addr, 1'b0, '0, $urandom);
      serve(1, 1'b0, w);
      if (k % 2 == 0) d_addr  = d_addr + 32'd4;
      else            if_addr = if_addr + 32'd4;
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // Store: d_rdata keeps the previous load value
    d_we = 1'b1; d_addr = 32'h0C; d_wdata = 32'h1E; d_req = 1'b1;
    push(GNT_DATA, 32'h0C, 1'b1, 32'h1E, $urandom);
    serve(2, 1'b1, w);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("store_d_rdata_hold", d_rdata, exp_d_rdata);

    // Reset while a data transaction is in flight
    d_addr = 32'h300; d_req = 1'b1;
    tick();
    chk("busy_before_reset", {31'd0, mem_req}, 32'd1);
    chk("busy_addr", mem_addr, 32'h300);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'd0);
    d_req = 1'b0;
    exp_if_rdata = '0; exp_d_rdata = '0;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_ack_after_reset", {30'd0, if_ack, d_ack}, 32'd0);
    end
    d_addr = 32'h400; if_addr = 32'h500; d_req = 1'b1; if_req = 1'b1;
    push(GNT_DATA, 32'h400, 1'b0, '0, 32'hC3C3_0003);
    push(GNT_FETCH, 32'h500, 1'b0, '0, 32'hD4D4_0004);
    serve(1, 1'b0, w);
    serve(2, 1'b0, w);
    d_req = 1'b0; if_req = 1'b0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // Memory never acks: watchdog fires after 4 BUSY cycles
    if_addr = 32'h600; if_req = 1'b1;
    tick();
    chk("to_busy_1", {31'd0, mem_req}, 32'd1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("to_busy_hold", {31'd0, mem_req}, 32'd1);
    end
    tick();
    chk("to_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_if_ack", {31'd0, if_ack}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_if_rdata_hold", if_rdata, exp_if_rdata);
    if_req = 1'b0;
    tick();
    chk("to_err_clear", {31'd0, err}, 32'd0);
`endif

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
